// File: rtl/mem_arbiter.sv
// Two-master memory arbiter. The CPU and the IOP take turns owning one
// synchronous RAM port, and they hand it over by writing a mailbox word.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_CPU    | CPU owns the port; its accesses pass straight through
//   ST_TO_IOP | idle gap after the CPU mailbox write; nobody is granted
//   ST_IOP    | IOP owns the port; its accesses pass straight through
//   ST_TO_CPU | idle gap after the IOP mailbox write; nobody is granted
module mem_arbiter #(
    parameter logic [16:0] MBOX_TO_IOP = 17'h20,
    parameter logic [16:0] MBOX_TO_CPU = 17'h21,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic [15:31] cpu_address,
    input  logic [0:3]   cpu_write_en,
    input  logic [0:31]  cpu_data_out,
    output logic         cpu_gnt,
    output logic [0:31]  cpu_data_in,
    output logic         cpu_rvalid,
    input  logic         iop_req,
    input  logic [15:31] iop_address,
    input  logic [0:3]   iop_write_en,
    input  logic [0:31]  iop_data_out,
    output logic         iop_gnt,
    output logic [0:31]  iop_data_in,
    output logic         iop_rvalid,
    output logic [15:31] memory_address,
    output logic [0:3]   mem_write_en,
    output logic [0:31]  memory_data_in,
    input  logic [0:31]  memory_data_out,
    output logic         cpu_active,
    output logic [1:0]   owner_state
);

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_TO_IOP = 2'd1,
        ST_IOP    = 2'd2,
        ST_TO_CPU = 2'd3
    } owner_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    owner_t         state_q, state_d;
    logic [3:0]     turn_q, turn_d;
    logic [15:31]   addr_q;
    logic [0:31]    data_q;
    logic           cpu_rvalid_q, cpu_rvalid_d;
    logic           iop_rvalid_q, iop_rvalid_d;
    logic           cpu_grant, iop_grant;

    // Grants: only the owner sees its request honoured. Reset is folded in so
    // nothing leaks to memory while reset is held, even between clock edges.
    always_comb begin
        cpu_grant = (state_q == ST_CPU) && cpu_req && !reset;
        iop_grant = (state_q == ST_IOP) && iop_req && !reset;
        cpu_gnt   = cpu_grant;
        iop_gnt   = iop_grant;
    end

    // Memory port mux: pass the granted master through, otherwise hold the
    // last address/data and suppress writes.
    always_comb begin
        memory_address = addr_q;
        memory_data_in = data_q;
        mem_write_en   = 4'b0000;
        if (cpu_grant) begin
            memory_address = cpu_address;
            memory_data_in = cpu_data_out;
            mem_write_en   = cpu_write_en;
        end else if (iop_grant) begin
            memory_address = iop_address;
            memory_data_in = iop_data_out;
            mem_write_en   = iop_write_en;
        end
    end

    // Next-state logic for ownership and the turnaround down-counter.
    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        cpu_rvalid_d = cpu_grant && (cpu_write_en == 4'b0000);
        iop_rvalid_d = iop_grant && (iop_write_en == 4'b0000);
        case (state_q)
            ST_CPU: begin
                if (cpu_grant && cpu_write_en[0] && (cpu_address == MBOX_TO_IOP)) begin
                    state_d = ST_TO_IOP;
                    turn_d  = TURN_LOAD;
                end
            end
            ST_TO_IOP: begin
                if (turn_q == 4'd0) begin
                    state_d = ST_IOP;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            ST_IOP: begin
                if (iop_grant && iop_write_en[0] && (iop_address == MBOX_TO_CPU)) begin
                    state_d = ST_TO_CPU;
                    turn_d  = TURN_LOAD;
                end
            end
            ST_TO_CPU: begin
                if (turn_q == 4'd0) begin
                    state_d = ST_CPU;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            default: state_d = ST_CPU;
        endcase
    end

    // State, counter, held memory port values and read-valid pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CPU;
            turn_q       <= 4'd0;
            addr_q       <= '0;
            data_q       <= '0;
            cpu_rvalid_q <= 1'b0;
            iop_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            addr_q       <= memory_address;
            data_q       <= memory_data_in;
            cpu_rvalid_q <= cpu_rvalid_d;
            iop_rvalid_q <= iop_rvalid_d;
        end
    end

    // Read data is shared; consumers qualify it with their own rvalid.
    always_comb begin
        cpu_data_in = memory_data_out;
        iop_data_in = memory_data_out;
        cpu_rvalid  = cpu_rvalid_q;
        iop_rvalid  = iop_rvalid_q;
        cpu_active  = (state_q == ST_CPU) || (state_q == ST_TO_CPU);
        owner_state = state_q;
    end

endmodule
